qracc_sram_arbiter: RTL and testbench

QRACC_SRAM_ARBITER -- requirements
Module: qracc_sram_arbiter

---
 rtl/qracc_pkg.sv | 11 +
 rtl/qracc_rr_pick.sv | 25 ++
 rtl/qracc_sram_arbiter.sv | 114 +++++++++++
 tb/tb_qracc_sram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// Shared types and default geometry for the QRACC SRAM arbiter.
package qracc_pkg;
  localparam int NUM_ROWS = 128;
  localparam int NUM_COLS = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_WAIT_RD = 2'd2
  } qracc_arb_state_t;
endpackage

// File: rtl/qracc_rr_pick.sv
// Combinational round-robin winner selection: the first valid requester
// found when searching upward from last_i+1, wrapping modulo numReq.
module qracc_rr_pick #(
  parameter int numReq = 2
) (
  input  logic [numReq-1:0]         valid_i,
  input  logic [$clog2(numReq)-1:0] last_i,
  output logic [$clog2(numReq)-1:0] winner_o,
  output logic                      any_o
);
  localparam int IW = $clog2(numReq);

  logic [IW-1:0] idx;

  // Walk from the farthest offset down to the nearest so the nearest valid wins.
  always_comb begin
    winner_o = '0;
    idx      = '0;
    any_o    = |valid_i;
    for (int i = numReq; i >= 1; i--) begin
      idx = IW'((int'(last_i) + i) % numReq);
      if (valid_i[idx]) winner_o = idx;
    end
  end
endmodule

// File: rtl/qracc_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM request port between numReq requesters,
// with at most one SRAM transaction outstanding.
module qracc_sram_arbiter
  import qracc_pkg::*;
#(
  parameter int numRows = NUM_ROWS,
  parameter int numCols = NUM_COLS,
  parameter int numReq  = 2
) (
  input  logic                                      clk,
  input  logic                                      nrst,
  input  logic                                      clear_i,
  input  logic [numReq-1:0]                         req_valid_i,
  input  logic [numReq-1:0]                         req_wr_i,
  input  logic [numReq-1:0][$clog2(numRows)-1:0]    req_addr_i,
  input  logic [numReq-1:0][numCols-1:0]            req_wdata_i,
  output logic [numReq-1:0]                         req_ready_o,
  output logic [numReq-1:0]                         rd_valid_o,
  output logic [numCols-1:0]                        rd_data_o,
  output logic                                      sram_rq_wr_o,
  output logic                                      sram_rq_valid_o,
  output logic [$clog2(numRows)-1:0]                sram_addr_o,
  output logic [numCols-1:0]                        sram_wr_data_o,
  input  logic                                      sram_rq_ready_i,
  input  logic                                      sram_rd_valid_i,
  input  logic [numCols-1:0]                        sram_rd_data_i,
  output logic [$clog2(numReq)-1:0]                 grant_o,
  output logic                                      busy_o
);
  localparam int IW = $clog2(numReq);

  qracc_arb_state_t state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    pick_winner;
  logic             pick_any;
  logic             sram_hs;

  qracc_rr_pick #(.numReq(numReq)) u_rr_pick (
    .valid_i  (req_valid_i),
    .last_i   (last_q),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  assign sram_hs = (state_q == S_GRANT) && req_valid_i[grant_q] && sram_rq_ready_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (sram_hs) last_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any && !clear_i) begin
          grant_d = pick_winner;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!req_valid_i[grant_q])  state_d = S_IDLE;
        else if (sram_rq_ready_i)   state_d = req_wr_i[grant_q] ? S_IDLE : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (sram_rd_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every transition; the rr pointer is left alone.
    if (clear_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IW'(numReq - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    req_ready_o     = '0;
    rd_valid_o      = '0;
    rd_data_o       = '0;
    sram_rq_valid_o = 1'b0;
    sram_rq_wr_o    = 1'b0;
    sram_addr_o     = '0;
    sram_wr_data_o  = '0;
    case (state_q)
      S_GRANT: begin
        sram_rq_valid_o      = req_valid_i[grant_q];
        sram_rq_wr_o         = req_wr_i[grant_q];
        sram_addr_o          = req_addr_i[grant_q];
        sram_wr_data_o       = req_wdata_i[grant_q];
        req_ready_o[grant_q] = sram_rq_ready_i;
      end
      S_WAIT_RD: begin
        // Read data is steered only while a read is actually awaited.
        if (sram_rd_valid_i && !clear_i) begin
          rd_valid_o[grant_q] = 1'b1;
          rd_data_o           = sram_rd_data_i;
        end
      end
      default: ;
    endcase
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE);
endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Scoreboard bench for qracc_sram_arbiter: directed stimulus queues expected
// SRAM requests and read returns; a negedge monitor pops and compares them.
module tb_qracc_sram_arbiter;
  localparam int NR = 2;
  localparam int AW = 7;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   nrst = 1'b0;
  logic                   clear_i = 1'b0;
  logic [NR-1:0]          req_valid_i = '0;
  logic [NR-1:0]          req_wr_i = '0;
  logic [NR-1:0][AW-1:0]  req_addr_i = '0;
  logic [NR-1:0][DW-1:0]  req_wdata_i = '0;
  logic [NR-1:0]          req_ready_o;
  logic [NR-1:0]          rd_valid_o;
  logic [DW-1:0]          rd_data_o;
  logic                   sram_rq_wr_o;
  logic                   sram_rq_valid_o;
  logic [AW-1:0]          sram_addr_o;
  logic [DW-1:0]          sram_wr_data_o;
  logic                   sram_rq_ready_i = 1'b0;
  logic                   sram_rd_valid_i = 1'b0;
  logic [DW-1:0]          sram_rd_data_i = '0;
  logic [0:0]             grant_o;
  logic                   busy_o;

  qracc_sram_arbiter #(.numRows(128), .numCols(DW), .numReq(NR)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .clear_i         (clear_i),
    .req_valid_i     (req_valid_i),
    .req_wr_i        (req_wr_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .req_ready_o     (req_ready_o),
    .rd_valid_o      (rd_valid_o),
    .rd_data_o       (rd_data_o),
    .sram_rq_wr_o    (sram_rq_wr_o),
    .sram_rq_valid_o (sram_rq_valid_o),
    .sram_addr_o     (sram_addr_o),
    .sram_wr_data_o  (sram_wr_data_o),
    .sram_rq_ready_i (sram_rq_ready_i),
    .sram_rd_valid_i (sram_rd_valid_i),
    .sram_rd_data_i  (sram_rd_data_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:0]    grant;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NR-1:0] ready;
  } sram_txn_t;

  typedef struct packed {
    logic [NR-1:0] vec;
    logic [DW-1:0] data;
  } rd_txn_t;

  sram_txn_t exp_sram[$];
  rd_txn_t   exp_rd[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every SRAM handshake and every read strobe against the queues.
  initial begin
    sram_txn_t act_s, exp_s;
    rd_txn_t   act_r, exp_r;
    forever begin
      @(negedge clk);
      if (sram_rq_valid_o && sram_rq_ready_i) begin
        act_s = {grant_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o, req_ready_o};
        if (exp_sram.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sram_unexpected: got %h required none", act_s);
        end else begin
          exp_s = exp_sram.pop_front();
          check("sram_txn", 64'(act_s), 64'(exp_s));
        end
      end
      if (|rd_valid_o) begin
        act_r = {rd_valid_o, rd_data_o};
        if (exp_rd.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_unexpected: got %h required none", act_r);
        end else begin
          exp_r = exp_rd.pop_front();
          check("rd_txn", 64'(act_r), 64'(exp_r));
        end
      end else begin
        vectors++;
        if (rd_data_o !== '0) begin
          miscompares++;
          $display("FAIL rd_data_idle: got %h required 0", rd_data_o);
        end
      end
    end
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL timeout: got no finish required finish within bound");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    // Reset state
    #2;
    check("rst_busy",   64'(busy_o), 64'(0));
    check("rst_grant",  64'(grant_o), 64'(0));
    check("rst_ready",  64'(req_ready_o), 64'(0));
    check("rst_rqv",    64'(sram_rq_valid_o), 64'(0));
    check("rst_rdv",    64'(rd_valid_o), 64'(0));
    #12 nrst = 1'b1;
    tick();

    // Single write from requester 0
    req_valid_i = 2'b01; req_wr_i = 2'b01;
    req_addr_i[0] = 7'd5; req_wdata_i[0] = 32'hDEADBEEF;
    sram_rq_ready_i = 1'b1;
    exp_sram.push_back({1'b0, 1'b1, 7'd5, 32'hDEADBEEF, 2'b01});
    @(negedge clk); check("wr_c1_no_rq", 64'(sram_rq_valid_o), 64'(0));
    tick();
    @(negedge clk); check("wr_c2_ready", 64'(req_ready_o), 64'(2'b01));
    tick();
    req_valid_i = 2'b00;
    @(negedge clk); check("wr_c3_busy", 64'(busy_o), 64'(0));
    tick();

    // Read from requester 1 with 4-cycle SRAM latency
    req_valid_i = 2'b10; req_wr_i = 2'b00;
    req_addr_i[1] = 7'd7; req_wdata_i[1] = 32'h11111111;
    exp_sram.push_back({1'b1, 1'b0, 7'd7, 32'h11111111, 2'b10});
    tick();
    tick();
    req_valid_i = 2'b00;
    tick(); tick(); tick();
    sram_rd_valid_i = 1'b1; sram_rd_data_i = 32'hCAFEF00D;
    exp_rd.push_back({2'b10, 32'hCAFEF00D});
    tick();
    sram_rd_valid_i = 1'b0; sram_rd_data_i = 32'h0BAD0BAD;
    @(negedge clk); check("rd_done_busy", 64'(busy_o), 64'(0));
    // Stray read strobe while idle must not reach any requester
    tick();
    sram_rd_valid_i = 1'b1;
    tick();
    sram_rd_valid_i = 1'b0;

    // Both requesters streaming writes: grants alternate starting at 0
    req_addr_i[0] = 7'd10; req_wdata_i[0] = 32'hA0A0A0A0;
    req_addr_i[1] = 7'd11; req_wdata_i[1] = 32'hB1B1B1B1;
    req_wr_i = 2'b11; req_valid_i = 2'b11;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) exp_sram.push_back({1'b0, 1'b1, 7'd10, 32'hA0A0A0A0, 2'b01});
      else            exp_sram.push_back({1'b1, 1'b1, 7'd11, 32'hB1B1B1B1, 2'b10});
    end
    repeat (12) tick();
    req_valid_i = 2'b00;
    tick();

    // SRAM back-pressure for 10 cycles
    sram_rq_ready_i = 1'b0;
    req_valid_i = 2'b01; req_wr_i = 2'b01;
    req_addr_i[0] = 7'd20; req_wdata_i[0] = 32'h12345678;
    exp_sram.push_back({1'b0, 1'b1, 7'd20, 32'h12345678, 2'b01});
    tick();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_hold", 64'({sram_rq_valid_o, sram_addr_o, sram_wr_data_o, req_ready_o, grant_o}),
            64'({1'b1, 7'd20, 32'h12345678, 2'b00, 1'b0}));
      tick();
    end
    sram_rq_ready_i = 1'b1;
    tick();
    req_valid_i = 2'b00;
    tick();

    // Pointer now at 0, so requester 1 wins a tie
    req_addr_i[0] = 7'd10; req_wdata_i[0] = 32'hA0A0A0A0;
    req_valid_i = 2'b11; req_wr_i = 2'b11;
    exp_sram.push_back({1'b1, 1'b1, 7'd11, 32'hB1B1B1B1, 2'b10});
    tick();
    tick();
    req_valid_i = 2'b00;
    tick();

    // Clear while waiting for read data; late data is dropped
    req_valid_i = 2'b01; req_wr_i = 2'b00; req_addr_i[0] = 7'd3;
    exp_sram.push_back({1'b0, 1'b0, 7'd3, 32'hA0A0A0A0, 2'b01});
    tick();
    tick();
    req_valid_i = 2'b00;
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    @(negedge clk); check("clr_busy", 64'(busy_o), 64'(0));
    sram_rd_valid_i = 1'b1; sram_rd_data_i = 32'h55AA55AA;
    tick();
    sram_rd_valid_i = 1'b0;
    @(negedge clk); check("clr_late_busy", 64'(busy_o), 64'(0));
    tick();

    // Async reset while in S_GRANT; requester 0 wins first afterwards
    req_addr_i[0] = 7'd10; req_wdata_i[0] = 32'hA0A0A0A0;
    sram_rq_ready_i = 1'b0;
    req_valid_i = 2'b11; req_wr_i = 2'b11;
    tick();
    check("prerst_busy", 64'(busy_o), 64'(1));
    check("prerst_grant", 64'(grant_o), 64'(1));
    #2 nrst = 1'b0;
    #1;
    check("arst_outs", 64'({sram_rq_valid_o, busy_o, grant_o, req_ready_o, rd_valid_o, sram_addr_o}), 64'(0));
    #2 nrst = 1'b1;
    sram_rq_ready_i = 1'b1;
    exp_sram.push_back({1'b0, 1'b1, 7'd10, 32'hA0A0A0A0, 2'b01});
    tick();
    tick();
    req_valid_i = 2'b00;
    repeat (3) tick();

    check("sram_queue_empty", 64'(exp_sram.size()), 64'(0));
    check("rd_queue_empty",   64'(exp_rd.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
